// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed display controller: sequential binary-to-BCD conversion plus digit scan.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits on positions 3..1.
module seven_seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value_in,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  bcd_out,
    input  logic [7:0]  seg_in,
    output logic [7:0]  seg_out,
    output logic [3:0]  an
);

    // state  | meaning
    // IDLE   | waiting for load; display shows last committed value
    // CONV   | 14 shift-add-3 iterations, one per clock
    // COMMIT | copy the finished BCD result into the display digits
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);
    localparam logic [13:0] VALUE_MAX  = 14'd9999;
    localparam logic [3:0]  ITER_LAST  = 4'd13;

    state_t           state;
    state_t           state_nxt;
    logic [29:0]      sh_reg;
    logic [29:0]      sh_nxt;
    logic [3:0]       iter;
    logic [3:0]       iter_nxt;
    logic             commit;

    logic [3:0][3:0]  dig;
    logic [3:0][3:0]  dig_nxt;
    logic [19:0]      presc;
    logic [19:0]      presc_nxt;
    logic             presc_wrap;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic [3:0]       bcd_nxt;
    logic [3:0]       an_nxt;
    logic [3:0]       an_onehot;

    // One double-dabble iteration on {bcd[15:0], bin[13:0]}: adjust nibbles, then shift.
    function automatic logic [29:0] dabble_step(input logic [29:0] r);
        logic [29:0] t;
        t = r;
        for (int i = 0; i < 4; i++) begin
            if (t[14 + 4*i +: 4] >= 4'd5) begin
                t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[28:0], 1'b0};
    endfunction

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh_reg;
        iter_nxt  = iter;
        commit    = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) begin
                    sh_nxt    = {16'd0, (value_in > VALUE_MAX) ? VALUE_MAX : value_in};
                    iter_nxt  = 4'd0;
                    state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                busy     = 1'b1;
                sh_nxt   = dabble_step(sh_reg);
                iter_nxt = iter + 4'd1;
                if (iter == ITER_LAST) begin
                    state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                busy      = 1'b1;
                commit    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output registers are loaded from next-state idx/dig so that a commit and a slot
    // advance on the same edge show the new digit on the new position immediately.
    always_comb begin
        presc_wrap = (presc == PRESC_LAST);
        presc_nxt  = presc_wrap ? 20'd0 : presc + 20'd1;
        idx_nxt    = presc_wrap ? idx + 2'd1 : idx;
        dig_nxt    = commit ? sh_reg[29:14] : dig;
        bcd_nxt    = dig_nxt[idx_nxt];
        an_onehot  = ~(4'b0001 << idx_nxt);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic blank3;
    logic blank2;
    logic blank1;
    logic slot_blank;

    always_comb begin
        blank3 = (dig_nxt[3] == 4'd0);
        blank2 = blank3 && (dig_nxt[2] == 4'd0);
        blank1 = blank2 && (dig_nxt[1] == 4'd0);
        case (idx_nxt)
            2'd3:    slot_blank = blank3;
            2'd2:    slot_blank = blank2;
            2'd1:    slot_blank = blank1;
            default: slot_blank = 1'b0;
        endcase
        an_nxt = slot_blank ? 4'b1111 : an_onehot;
    end
`else
    always_comb begin
        an_nxt = an_onehot;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sh_reg  <= '0;
            iter    <= '0;
            dig     <= '0;
            presc   <= '0;
            idx     <= '0;
            bcd_out <= '0;
            an      <= 4'b1110;
        end else begin
            state   <= state_nxt;
            sh_reg  <= sh_nxt;
            iter    <= iter_nxt;
            dig     <= dig_nxt;
            presc   <= presc_nxt;
            idx     <= idx_nxt;
            bcd_out <= bcd_nxt;
            an      <= an_nxt;
        end
    end

    assign seg_out = seg_in;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with a short scan period.
// Expected display is derived arithmetically from the value and a free cycle count.
module tb_seven_seg_scan_ctrl;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst;
    logic [13:0] value_in;
    logic        load;
    logic        busy;
    logic [3:0]  bcd_out;
    logic [7:0]  seg_in;
    logic [7:0]  seg_out;
    logic [3:0]  an;

    int n_cmp;
    int n_fail;
    int cyc;
    int disp;

    seven_seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .load     (load),
        .busy     (busy),
        .bcd_out  (bcd_out),
        .seg_in   (seg_in),
        .seg_out  (seg_out),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since reset released; the active slot is cyc / SCAN_DIV mod 4.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [3:0] digit_of(input int val, input int pos);
        int p;
        p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        return 4'((val / p) % 10);
    endfunction

    function automatic logic [3:0] exp_an(input int val, input int pos);
        logic [3:0] a;
        int p;
        a = 4'b1111;
        a[pos] = 1'b0;
        p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos != 0 && val < p) a = 4'b1111;
`endif
        return a;
    endfunction

    function automatic int cur_slot();
        return (cyc / SCAN_DIV) % 4;
    endfunction

    task automatic test_reset();
        int s;
        rst = 1'b1;
        value_in = '0;
        load = 1'b0;
        seg_in = '0;
        #1;
        n_cmp++;
        if (an !== 4'b1110 || bcd_out !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got an=%b bcd=%0d busy=%b, expected an=1110 bcd=0 busy=0", an, bcd_out, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        disp = 0;
        for (int k = 0; k < 4 * SCAN_DIV * 2; k++) begin
            @(negedge clk);
            s = cur_slot();
            n_cmp++;
            if (an !== exp_an(disp, s)) begin
                n_fail++;
                $display("FAIL reset_scan_an k=%0d: got %b, expected %b", k, an, exp_an(disp, s));
            end
            n_cmp++;
            if (bcd_out !== 4'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_scan_idle k=%0d: got bcd=%0d busy=%b, expected bcd=0 busy=0", k, bcd_out, busy);
            end
        end
    endtask

    // Starts at a negedge with the DUT idle; optionally pulses an ignored load at offset ign_at.
    task automatic test_conversion(input int v, input int ign_at, input int ign_v, input string tag);
        int newv;
        int oldv;
        int shown;
        int s;
        logic exp_busy;
        newv = sat(v);
        oldv = disp;
        value_in = 14'(v);
        load = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (k == ign_at) begin
                value_in = 14'(ign_v);
                load = 1'b1;
            end
            exp_busy = (k <= 14);
            shown = (k >= 15) ? newv : oldv;
            s = cur_slot();
            n_cmp++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL %s_busy k=%0d: got %b, expected %b", tag, k, busy, exp_busy);
            end
            n_cmp++;
            if (bcd_out !== digit_of(shown, s)) begin
                n_fail++;
                $display("FAIL %s_bcd k=%0d slot=%0d: got %0d, expected %0d", tag, k, s, bcd_out, digit_of(shown, s));
            end
            n_cmp++;
            if (an !== exp_an(shown, s)) begin
                n_fail++;
                $display("FAIL %s_an k=%0d slot=%0d: got %b, expected %b", tag, k, s, an, exp_an(shown, s));
            end
        end
        disp = newv;
    endtask

    task automatic test_basic();
        test_conversion(1234, -1, 0, "v1234");
    endtask

    task automatic test_saturation();
        test_conversion(12000, -1, 0, "sat12000");
        test_conversion(16383, -1, 0, "sat16383");
        test_conversion(9999, -1, 0, "max9999");
    endtask

    task automatic test_ignored_load();
        test_conversion(5678, 5, 4321, "ign_conv");
        test_conversion(2468, 14, 1357, "ign_commit");
    endtask

    task automatic test_small_values();
        test_conversion(7, -1, 0, "v7");
        test_conversion(0, -1, 0, "v0");
        test_conversion(305, -1, 0, "v305");
        test_conversion(40, -1, 0, "v40");
    endtask

    task automatic test_reset_mid();
        value_in = 14'd9876;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || an !== 4'b1110 || bcd_out !== 4'd0) begin
            n_fail++;
            $display("FAIL midrst_async: got busy=%b an=%b bcd=%0d, expected busy=0 an=1110 bcd=0", busy, an, bcd_out);
        end
        #1 rst = 1'b0;
        disp = 0;
        for (int k = 0; k < 4 * SCAN_DIV; k++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || bcd_out !== 4'd0 || an !== exp_an(0, cur_slot())) begin
                n_fail++;
                $display("FAIL midrst_after k=%0d: got busy=%b bcd=%0d an=%b, expected busy=0 bcd=0 an=%b",
                         k, busy, bcd_out, an, exp_an(0, cur_slot()));
            end
        end
        test_conversion(42, -1, 0, "after_rst42");
    endtask

    task automatic test_random();
        int v;
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            v = int'($urandom_range(0, 16383));
            test_conversion(v, -1, 0, "rand");
        end
    endtask

    task automatic test_passthrough();
        logic [7:0] pat;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pat = 8'($urandom);
            seg_in = pat;
            #1;
            n_cmp++;
            if (seg_out !== pat) begin
                n_fail++;
                $display("FAIL seg_pass k=%0d: got %h, expected %h", k, seg_out, pat);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        disp = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_ignored_load();
        test_small_values();
        test_reset_mid();
        test_random();
        test_passthrough();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
